// File: rtl/up_counter_mod.sv
`default_nettype none
// ============================================================================
// Module   : up_counter_mod
// Brief    : Modulo up-counter (0..MAX) with enable, sync clear and
//            terminal-count flag.
// Revision : 1.0 - initial release
// ============================================================================
module up_counter_mod #(
    parameter int unsigned BITS = 8,
    parameter int unsigned MAX  = 255
) (
    input  logic            en,
    input  logic            clr,
    output logic [BITS-1:0] count,
    input  logic            clk,
    input  logic            rst_n,
    output logic            tc
);

    localparam logic [BITS-1:0] c_max = MAX[BITS-1:0];
    localparam logic [BITS-1:0] c_one = BITS'(1);

    // Declaration initializer gives a defined power-up value without reset.
    logic [BITS-1:0] r_count = '0;
    logic [BITS-1:0] w_next;
    logic            w_at_max;

    assign w_at_max = (r_count == c_max);
    assign w_next   = w_at_max ? '0 : (r_count + c_one);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_next;
        end
    end

    assign count = r_count;
    assign tc    = w_at_max;

endmodule
`default_nettype wire

// File: tb/tb_up_counter_mod.sv
`default_nettype none
// ============================================================================
// Module   : tb_up_counter_mod
// Brief    : Directed self-checking bench for up_counter_mod.
// Revision : 1.0 - initial release
// ============================================================================
module tb_up_counter_mod;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [7:0] count;
    logic       tc;
    logic [7:0] count0;
    logic       tc0;
    logic [3:0] count4;
    logic       tc4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    up_counter_mod #(.BITS(8), .MAX(15)) dut (
        .en(en), .clr(clr), .count(count), .clk(clk), .rst_n(rst_n), .tc(tc)
    );

    up_counter_mod #(.BITS(8), .MAX(0)) dut_max0 (
        .en(en), .clr(clr), .count(count0), .clk(clk), .rst_n(rst_n), .tc(tc0)
    );

    up_counter_mod #(.BITS(4), .MAX(15)) dut_bits4 (
        .en(en), .clr(clr), .count(count4), .clk(clk), .rst_n(rst_n), .tc(tc4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_powerup();
        #1;
        n_checks++;
        if (count !== 8'd0) $display("FAIL powerup_count: got %0d want 0", count);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (count !== 8'd0 || tc !== 1'b0)
                $display("FAIL reset_hold[%0d]: got count=%0d tc=%0b want count=0 tc=0", i, count, tc);
            else n_pass++;
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++;
            if (count !== 8'(i))
                $display("FAIL reset_release[%0d]: got %0d want %0d", i, count, i);
            else n_pass++;
        end
    endtask

    task automatic go_zero();
        rst_n = 1'b0; clr = 1'b0; en = 1'b1;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        logic [7:0] exp;
        go_zero();
        for (int i = 0; i < 20; i++) begin
            exp = 8'(i % 16);
            n_checks++;
            if (count !== exp || tc !== (exp == 8'd15))
                $display("FAIL wrap[%0d]: got count=%0d tc=%0b want count=%0d tc=%0b",
                         i, count, tc, exp, (exp == 8'd15));
            else n_pass++;
            step();
        end
    endtask

    task automatic test_enable_hold();
        go_zero();
        for (int i = 0; i < 7; i++) step();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (count !== 8'd7) $display("FAIL enable_hold[%0d]: got %0d want 7", i, count);
            else n_pass++;
        end
        en = 1'b1;
        step();
        n_checks++;
        if (count !== 8'd8) $display("FAIL enable_resume: got %0d want 8", count);
        else n_pass++;
    endtask

    task automatic test_clear();
        go_zero();
        for (int i = 0; i < 9; i++) step();
        n_checks++;
        if (count !== 8'd9) $display("FAIL clear_setup: got %0d want 9", count);
        else n_pass++;
        clr = 1'b1;
        step();
        n_checks++;
        if (count !== 8'd0) $display("FAIL clear_mid: got %0d want 0", count);
        else n_pass++;
        clr = 1'b0;
        for (int i = 0; i < 15; i++) step();
        n_checks++;
        if (count !== 8'd15 || tc !== 1'b1)
            $display("FAIL clear_at_max_setup: got count=%0d tc=%0b want count=15 tc=1", count, tc);
        else n_pass++;
        clr = 1'b1;
        step();
        n_checks++;
        if (count !== 8'd0 || tc !== 1'b0)
            $display("FAIL clear_at_max: got count=%0d tc=%0b want count=0 tc=0", count, tc);
        else n_pass++;
        clr = 1'b0;
        step();
        n_checks++;
        if (count !== 8'd1) $display("FAIL clear_release: got %0d want 1", count);
        else n_pass++;
    endtask

    task automatic test_reset_priority();
        go_zero();
        for (int i = 0; i < 12; i++) step();
        n_checks++;
        if (count !== 8'd12) $display("FAIL rstpri_setup: got %0d want 12", count);
        else n_pass++;
        rst_n = 1'b0;
        step();
        n_checks++;
        if (count !== 8'd0) $display("FAIL rst_over_en: got %0d want 0", count);
        else n_pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (count !== 8'd3) $display("FAIL rstpri_resume: got %0d want 3", count);
        else n_pass++;
        rst_n = 1'b0; clr = 1'b1;
        step();
        n_checks++;
        if (count !== 8'd0) $display("FAIL rst_over_clr: got %0d want 0", count);
        else n_pass++;
        rst_n = 1'b1; clr = 1'b0;
        step();
        n_checks++;
        if (count !== 8'd1) $display("FAIL rst_clr_release: got %0d want 1", count);
        else n_pass++;
    endtask

    task automatic test_max_zero();
        go_zero();
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (count0 !== 8'd0 || tc0 !== 1'b1)
                $display("FAIL max0[%0d]: got count=%0d tc=%0b want count=0 tc=1", i, count0, tc0);
            else n_pass++;
        end
    endtask

    task automatic test_bits4();
        logic [3:0] exp;
        go_zero();
        for (int i = 0; i < 18; i++) begin
            exp = 4'(i % 16);
            n_checks++;
            if (count4 !== exp || tc4 !== (exp == 4'd15))
                $display("FAIL bits4[%0d]: got count=%0d tc=%0b want count=%0d tc=%0b",
                         i, count4, tc4, exp, (exp == 4'd15));
            else n_pass++;
            step();
        end
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; clr = 1'b0;
        test_powerup();
        test_reset();
        test_wrap();
        test_enable_hold();
        test_clear();
        test_reset_priority();
        test_max_zero();
        test_bits4();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
